// File: rtl/sata_pkg.sv
// sata_pkg: FIS/ATA constants, status codes and FSM states shared by the command issue path
package sata_pkg;
   localparam logic [7:0] FIS_TYPE_REG_H2D  = 8'h27;
   localparam logic [7:0] ATA_READ_DMA_EXT  = 8'h25;
   localparam logic [7:0] ATA_WRITE_DMA_EXT = 8'h35;
   typedef enum logic [1:0] {ST_OK, ST_DEV_ERR, ST_TX_FAIL, ST_TIMEOUT} st_code_t;
   typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_TX, S_WAIT_CMD} cmd_state_t;
endpackage

// File: rtl/sata_cmd_watchdog.sv
// sata_cmd_watchdog: saturating WAIT_CMD cycle timer, built only when SATA_CMD_TIMEOUT_EN is defined
`ifdef SATA_CMD_TIMEOUT_EN
module sata_cmd_watchdog #(
   parameter int TIMEOUT = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic exp_o
);
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] cnt_q, cnt_d;
   // restart from zero while cleared, count enabled cycles and hold at TIMEOUT
   always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != TW'(TIMEOUT)) ? cnt_q + 1'b1 : cnt_q;
   // timer register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
   assign exp_o = en_i & (cnt_q == TW'(TIMEOUT - 1));
endmodule
`endif

// File: rtl/sata_cmd_issue_ctrl.sv
// sata_cmd_issue_ctrl: round-robin read/write command scheduler feeding the H2D Register FIS sender (optional WAIT_CMD timeout under SATA_CMD_TIMEOUT_EN)
module sata_cmd_issue_ctrl
   import sata_pkg::*;
#(
   parameter int MAX_RETRY = 3
`ifdef SATA_CMD_TIMEOUT_EN
   , parameter int TIMEOUT = 1000000
`endif
) (
   input  logic        reset,
   input  logic        clk,
   input  logic [47:0] rd_addr,
   input  logic [15:0] rd_scount,
   input  logic        rd_val,
   output logic        rd_rdy,
   input  logic [47:0] wr_addr,
   input  logic [15:0] wr_scount,
   input  logic        wr_val,
   output logic        wr_rdy,
   output logic [7:0]  fis_type,
   output logic [7:0]  fis_command,
   output logic [47:0] fis_address,
   output logic [15:0] fis_scount,
   output logic        fis_val,
   input  logic        fis_rdy,
   input  logic        tx_done,
   input  logic        tx_err,
   input  logic        cmd_ok,
   input  logic        cmd_err,
   output logic        st_val,
   output logic [1:0]  st_code,
   output logic        st_is_wr,
   output logic        busy
);
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   cmd_state_t    state_q, state_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [47:0]   addr_q, addr_d;
   logic [15:0]   scount_q, scount_d;
   logic [7:0]    cmd_q, cmd_d;
   logic          is_wr_q, is_wr_d, last_wr_q, last_wr_d;
   logic          st_val_q, st_val_d, st_is_wr_q, st_is_wr_d;
   st_code_t      st_code_q, st_code_d;
   logic          idle, gnt_wr, gnt_rd, tmo;

   assign idle   = state_q == S_IDLE;
   assign gnt_wr = wr_val & (~rd_val | ~last_wr_q);
   assign gnt_rd = rd_val & ~gnt_wr;
   assign rd_rdy = idle & gnt_rd;
   assign wr_rdy = idle & gnt_wr;

`ifdef SATA_CMD_TIMEOUT_EN
   sata_cmd_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk   (clk),
      .reset (reset),
      .clr_i (state_q != S_WAIT_CMD),
      .en_i  (state_q == S_WAIT_CMD),
      .exp_o (tmo)
   );
`else
   assign tmo = 1'b0;
`endif

   // next state: accept/latch in IDLE, retry on tx_err, terminate with one registered status
   always_comb begin
      state_d    = state_q;
      retry_d    = retry_q;
      addr_d     = addr_q;
      scount_d   = scount_q;
      cmd_d      = cmd_q;
      is_wr_d    = is_wr_q;
      last_wr_d  = last_wr_q;
      st_val_d   = 1'b0;
      st_code_d  = st_code_q;
      st_is_wr_d = st_is_wr_q;
      case (state_q)
         S_IDLE: if (gnt_wr | gnt_rd) begin
            state_d   = S_SEND;
            retry_d   = '0;
            is_wr_d   = gnt_wr;
            last_wr_d = gnt_wr;
            addr_d    = gnt_wr ? wr_addr : rd_addr;
            scount_d  = gnt_wr ? wr_scount : rd_scount;
            cmd_d     = gnt_wr ? ATA_WRITE_DMA_EXT : ATA_READ_DMA_EXT;
         end
         S_SEND: if (fis_rdy) state_d = S_WAIT_TX;
         S_WAIT_TX: if (tx_err) begin
            if (retry_q < RW'(MAX_RETRY)) begin
               retry_d = retry_q + 1'b1;
               state_d = S_SEND;
            end else begin
               state_d    = S_IDLE;
               st_val_d   = 1'b1;
               st_code_d  = ST_TX_FAIL;
               st_is_wr_d = is_wr_q;
            end
         end else if (tx_done) state_d = S_WAIT_CMD;
         S_WAIT_CMD: if (cmd_ok | cmd_err | tmo) begin
            state_d    = S_IDLE;
            st_val_d   = 1'b1;
            st_is_wr_d = is_wr_q;
            st_code_d  = cmd_err ? ST_DEV_ERR : cmd_ok ? ST_OK : ST_TIMEOUT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state, latched command and status registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         retry_q    <= '0;
         addr_q     <= '0;
         scount_q   <= '0;
         cmd_q      <= '0;
         is_wr_q    <= 1'b0;
         last_wr_q  <= 1'b1;
         st_val_q   <= 1'b0;
         st_code_q  <= ST_OK;
         st_is_wr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         retry_q    <= retry_d;
         addr_q     <= addr_d;
         scount_q   <= scount_d;
         cmd_q      <= cmd_d;
         is_wr_q    <= is_wr_d;
         last_wr_q  <= last_wr_d;
         st_val_q   <= st_val_d;
         st_code_q  <= st_code_d;
         st_is_wr_q <= st_is_wr_d;
      end
   end

   assign fis_type    = FIS_TYPE_REG_H2D;
   assign fis_command = cmd_q;
   assign fis_address = addr_q;
   assign fis_scount  = scount_q;
   assign fis_val     = state_q == S_SEND;
   assign st_val      = st_val_q;
   assign st_code     = st_code_q;
   assign st_is_wr    = st_is_wr_q;
   assign busy        = ~idle;
endmodule

// File: tb/tb_sata_cmd_issue_ctrl.sv
// tb_sata_cmd_issue_ctrl: table-driven command vectors plus reset, ignored-pulse and timeout sequences
module tb_sata_cmd_issue_ctrl;
   localparam int MR = 3;
   logic        reset, clk = 1'b0;
   logic [47:0] rd_addr, wr_addr, fis_address;
   logic [15:0] rd_scount, wr_scount, fis_scount;
   logic        rd_val, rd_rdy, wr_val, wr_rdy, fis_val, fis_rdy;
   logic        tx_done, tx_err, cmd_ok, cmd_err, st_val, st_is_wr, busy;
   logic [7:0]  fis_type, fis_command;
   logic [1:0]  st_code;
   int          n_vec = 0, n_bad = 0;

   typedef struct {
      logic rv, wv; logic [47:0] ra; logic [15:0] rs; logic [47:0] wa; logic [15:0] ws;
      int ntxe; logic dual, cok, cerr;
      logic e_wr; logic [7:0] e_cmd; logic [47:0] e_addr; logic [15:0] e_sc; int e_sends; logic [1:0] e_code;
   } vec_t;
   vec_t vt[13];

   sata_cmd_issue_ctrl #(
      .MAX_RETRY(MR)
`ifdef SATA_CMD_TIMEOUT_EN
      , .TIMEOUT(16)
`endif
   ) dut (
      .reset(reset), .clk(clk),
      .rd_addr(rd_addr), .rd_scount(rd_scount), .rd_val(rd_val), .rd_rdy(rd_rdy),
      .wr_addr(wr_addr), .wr_scount(wr_scount), .wr_val(wr_val), .wr_rdy(wr_rdy),
      .fis_type(fis_type), .fis_command(fis_command), .fis_address(fis_address),
      .fis_scount(fis_scount), .fis_val(fis_val), .fis_rdy(fis_rdy),
      .tx_done(tx_done), .tx_err(tx_err), .cmd_ok(cmd_ok), .cmd_err(cmd_err),
      .st_val(st_val), .st_code(st_code), .st_is_wr(st_is_wr), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, expected finish before 500000");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic send_once(input bit first, input vec_t v, inout int sends);
      int w;
      for (w = 0; w < 10; w++) begin
         @(negedge clk);
         if (fis_val) break;
      end
      chk("fis_lat", w, 0);
      if (first) begin
         chk("fis_type", fis_type, 8'h27);
         chk("fis_command", fis_command, v.e_cmd);
         chk("fis_address", fis_address, v.e_addr);
         chk("fis_scount", fis_scount, v.e_sc);
      end
      fis_rdy = 1'b1;
      cyc;
      fis_rdy = 1'b0;
      sends++;
   endtask

   task automatic accept(input logic rv, input logic wv, input logic e_wr);
      int w;
      rd_val = rv;
      wr_val = wv;
      for (w = 0; w < 10; w++) begin
         @(negedge clk);
         if ((rd_val & rd_rdy) | (wr_val & wr_rdy)) break;
      end
      chk("accept_wait", w, 0);
      chk("one_rdy", rd_rdy & wr_rdy, 0);
      chk("grant_wr", wr_val & wr_rdy, e_wr);
      cyc;
      rd_val = 1'b0;
      wr_val = 1'b0;
   endtask

   task automatic run(input vec_t v);
      int w, sends;
      sends = 0;
      rd_addr = v.ra; rd_scount = v.rs; wr_addr = v.wa; wr_scount = v.ws;
      accept(v.rv, v.wv, v.e_wr);
      chk("busy_after_accept", busy, 1);
      for (int k = 0; k < v.ntxe; k++) begin
         send_once(k == 0, v, sends);
         tx_err = 1'b1;
         tx_done = v.dual && k == 0;
         cyc;
         tx_err = 1'b0;
         tx_done = 1'b0;
      end
      if (v.ntxe <= MR) begin
         send_once(v.ntxe == 0, v, sends);
         tx_done = 1'b1;
         cyc;
         tx_done = 1'b0;
         repeat (2) cyc;
         cmd_ok = v.cok;
         cmd_err = v.cerr;
         cyc;
         cmd_ok = 1'b0;
         cmd_err = 1'b0;
      end
      for (w = 0; w < 10; w++) begin
         @(negedge clk);
         if (st_val) break;
      end
      chk("st_lat", w, 0);
      chk("st_code", st_code, v.e_code);
      chk("st_is_wr", st_is_wr, v.e_wr);
      chk("busy_at_status", busy, 0);
      chk("sends", sends, v.e_sends);
      cyc;
      chk("st_pulse_width", st_val, 0);
   endtask

   initial begin
      int w, seen, sends;
      vec_t dv;
      vt[0]  = '{1'b1, 1'b1, 48'h1000, 16'd1, 48'h2000, 16'd2, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h25, 48'h1000, 16'd1, 1, 2'd0};
      vt[1]  = '{1'b1, 1'b1, 48'h1001, 16'd3, 48'h2001, 16'd4, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h35, 48'h2001, 16'd4, 1, 2'd0};
      vt[2]  = '{1'b1, 1'b1, 48'h1002, 16'd5, 48'h2002, 16'd6, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h25, 48'h1002, 16'd5, 1, 2'd0};
      vt[3]  = '{1'b1, 1'b1, 48'h1003, 16'd7, 48'h2003, 16'd8, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h35, 48'h2003, 16'd8, 1, 2'd0};
      vt[4]  = '{1'b1, 1'b0, 48'h0000_0012_3456, 16'd8, 48'h0, 16'd0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h25, 48'h0000_0012_3456, 16'd8, 1, 2'd0};
      vt[5]  = '{1'b0, 1'b1, 48'h0, 16'd0, 48'h0000_ABCD_0000, 16'h0100, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h35, 48'h0000_ABCD_0000, 16'h0100, 1, 2'd0};
      vt[6]  = '{1'b1, 1'b1, 48'h5555_0000_0001, 16'h0020, 48'h6666_0000_0002, 16'h0040, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h25, 48'h5555_0000_0001, 16'h0020, 1, 2'd0};
      vt[7]  = '{1'b1, 1'b0, 48'h3000, 16'd9, 48'h0, 16'd0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 8'h25, 48'h3000, 16'd9, 4, 2'd2};
      vt[8]  = '{1'b0, 1'b1, 48'h0, 16'd0, 48'h4000, 16'd10, 2, 1'b0, 1'b1, 1'b0, 1'b1, 8'h35, 48'h4000, 16'd10, 3, 2'd0};
      vt[9]  = '{1'b1, 1'b0, 48'h4100, 16'd11, 48'h0, 16'd0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h25, 48'h4100, 16'd11, 2, 2'd0};
      vt[10] = '{1'b0, 1'b1, 48'h0, 16'd0, 48'h4200, 16'd12, 0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h35, 48'h4200, 16'd12, 1, 2'd1};
      vt[11] = '{1'b1, 1'b0, 48'h4300, 16'd13, 48'h0, 16'd0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h25, 48'h4300, 16'd13, 1, 2'd1};
      vt[12] = '{1'b0, 1'b1, 48'h0, 16'd0, 48'hFFFF_FFFF_FFFF, 16'h0000, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h35, 48'hFFFF_FFFF_FFFF, 16'h0000, 1, 2'd0};
      dv = vt[4];
      reset = 1'b1;
      rd_addr = '0; rd_scount = '0; rd_val = 1'b0; wr_addr = '0; wr_scount = '0; wr_val = 1'b0;
      fis_rdy = 1'b0; tx_done = 1'b0; tx_err = 1'b0; cmd_ok = 1'b0; cmd_err = 1'b0;
      #1;
      chk("rst_fis_val", fis_val, 0);
      chk("rst_st_val", st_val, 0);
      chk("rst_st_code", st_code, 0);
      chk("rst_st_is_wr", st_is_wr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fis_address", fis_address, 0);
      chk("rst_fis_scount", fis_scount, 0);
      chk("rst_fis_command", fis_command, 0);
      repeat (2) cyc;
      reset = 1'b0;
      cyc;
      tx_err = 1'b1; tx_done = 1'b1; cmd_ok = 1'b1; cmd_err = 1'b1;
      cyc;
      tx_err = 1'b0; tx_done = 1'b0; cmd_ok = 1'b0; cmd_err = 1'b0;
      @(negedge clk);
      chk("idle_ignore_st_val", st_val, 0);
      chk("idle_ignore_busy", busy, 0);
      cyc;
      for (int i = 0; i < 13; i++) run(vt[i]);
      rd_addr = 48'h7000; rd_scount = 16'd1;
      accept(1'b1, 1'b0, 1'b0);
      sends = 0;
      send_once(1'b0, dv, sends);
      tx_done = 1'b1;
      cyc;
      tx_done = 1'b0;
`ifdef SATA_CMD_TIMEOUT_EN
      for (w = 0; w < 40; w++) begin
         @(negedge clk);
         if (st_val) break;
      end
      chk("timeout_lat", w, 16);
      chk("timeout_code", st_code, 2'd3);
      cyc;
`else
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         seen += int'(st_val);
      end
      chk("no_timeout_st", seen, 0);
      chk("no_timeout_busy", busy, 1);
      cyc;
      cmd_ok = 1'b1;
      cyc;
      cmd_ok = 1'b0;
      @(negedge clk);
      chk("late_cmd_ok_st", st_val, 1);
      chk("late_cmd_ok_code", st_code, 2'd0);
      cyc;
`endif
      rd_addr = 48'h8000; rd_scount = 16'd2;
      accept(1'b1, 1'b0, 1'b0);
      sends = 0;
      send_once(1'b0, dv, sends);
      chk("pre_reset_busy", busy, 1);
      reset = 1'b1;
      #1;
      chk("reset_fis_val", fis_val, 0);
      chk("reset_busy", busy, 0);
      chk("reset_st_val", st_val, 0);
      repeat (2) cyc;
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         seen += int'(st_val);
      end
      chk("reset_silent", seen, 0);
      cyc;
      run(vt[0]);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
